// File: rtl/truth_table_extractor_pkg.sv
// Shared types and constants for the 3-input truth-table extractor.
// The row-to-bit mapping matches the hex naming used for the gate modules.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int TT_ROWS   = 8;
  localparam int TT_CODE_W = 8;

  // Row 3'b000 lands in the MSB so the code reads like the gate name (e.g. 0x39).
  function automatic logic [2:0] tt_bit_of_row(input logic [2:0] row);
    return 3'(TT_ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/truth_table_extractor_if.sv
// Controller-side handshake plus gate-side drive/sense for the extractor.
// slave = the extractor, master = whoever requests sweeps and models the gate.
interface truth_table_extractor_if;
  logic       start;
  logic       busy;
  logic [2:0] dut_in;
  logic       dut_out;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       unstable;

  modport slave (
    input  start, dut_out, code_ready,
    output busy, dut_in, code, code_valid, unstable
  );

  modport master (
    output start, dut_out, code_ready,
    input  busy, dut_in, code, code_valid, unstable
  );
endinterface

// File: rtl/truth_table_extractor_row_sampler.sv
// Per-row timing: counts the settle window, then samples dut_out on consecutive
// cycles and flags any sample that disagrees with the first one of the row.
module tt_row_sampler #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_SAMPLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic settle_en,
  input  logic sample_en,
  input  logic dut_out,
  output logic settle_done,
  output logic sample_done,
  output logic sample_bit,
  output logic mismatch
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SAMPLE_W = $clog2(STABLE_SAMPLES + 1);

  logic [SETTLE_W-1:0] settle_cnt;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic                first_q;

  assign settle_done = settle_en && (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign sample_done = sample_en && (sample_cnt == SAMPLE_W'(STABLE_SAMPLES - 1));
  assign sample_bit  = dut_out;
  assign mismatch    = sample_en && (sample_cnt != '0) && (dut_out != first_q);

  // Counters idle at zero so every row starts its windows from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      first_q    <= 1'b0;
    end else begin
      if (settle_en && !settle_done) settle_cnt <= settle_cnt + 1'b1;
      else                           settle_cnt <= '0;

      if (sample_en && !sample_done) sample_cnt <= sample_cnt + 1'b1;
      else                           sample_cnt <= '0;

      if (sample_en && (sample_cnt == '0)) first_q <= dut_out;
    end
  end

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all eight input rows of a 3-input gate and assembles its truth-table
// code; the result is held behind a valid/ready handshake.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_SAMPLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_extractor_if.slave bus
);

  tt_state_e              state, state_nxt;
  logic [2:0]             row;
  logic [2:0]             dut_in_q;
  logic [TT_CODE_W-1:0]   code_q;
  logic                   code_valid_q;
  logic                   busy_q;
  logic                   unstable_q;
  logic                   settle_en, sample_en;
  logic                   settle_done, sample_done, sample_bit, mismatch;
  logic                   handshake;

  assign settle_en = (state == SETTLE);
  assign sample_en = (state == SAMPLE);
  assign handshake = code_valid_q && bus.code_ready;

  tt_row_sampler #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .STABLE_SAMPLES(STABLE_SAMPLES)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .settle_en  (settle_en),
    .sample_en  (sample_en),
    .dut_out    (bus.dut_out),
    .settle_done(settle_done),
    .sample_done(sample_done),
    .sample_bit (sample_bit),
    .mismatch   (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  if (sample_done) state_nxt = (row == 3'(TT_ROWS - 1)) ? DONE : SETTLE;
      DONE:    if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE spends one cycle committing before code_valid rises; busy drops with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row          <= '0;
      dut_in_q     <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      unstable_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            row        <= '0;
            dut_in_q   <= '0;
            code_q     <= '0;
            unstable_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) unstable_q <= 1'b1;
          if (sample_done) begin
            code_q[tt_bit_of_row(row)] <= sample_bit;
            if (row == 3'(TT_ROWS - 1)) begin
              dut_in_q <= '0;
            end else begin
              row      <= row + 1'b1;
              dut_in_q <= row + 1'b1;
            end
          end
        end
        DONE: begin
          if (!code_valid_q) begin
            code_valid_q <= 1'b1;
            busy_q       <= 1'b0;
          end else if (bus.code_ready) begin
            code_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in     = dut_in_q;
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.busy       = busy_q;
  assign bus.unstable   = unstable_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench: gate models driven from a code table, latency/handshake,
// backpressure, async reset and a minimum-timing instance.
module tb_truth_table_extractor;
  import tt_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  truth_table_extractor_if a ();
  truth_table_extractor_if b ();

  truth_table_extractor #(.SETTLE_CYCLES(4), .STABLE_SAMPLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave)
  );
  truth_table_extractor #(.SETTLE_CYCLES(1), .STABLE_SAMPLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: the output for a row is the code bit named by that row.
  logic [7:0] model_a, model_b;
  logic       toggle_a;
  int         cyc_a;

  always @(posedge clk) cyc_a <= (a.dut_in == 3'b010) ? cyc_a + 1 : 0;

  // Toggle model: high only on the first sample cycle of row 010, so the
  // two samples disagree and the last one is 0.
  assign a.dut_out = (toggle_a && a.dut_in == 3'b010) ? (cyc_a == 4) :
                     model_a[tt_bit_of_row(a.dut_in)];
  assign b.dut_out = model_b[tt_bit_of_row(b.dut_in)];

  typedef struct {
    logic [7:0] model;
    logic       toggle;
    logic [7:0] exp_code;
    logic       exp_unstable;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_a();
    @(negedge clk); a.start = 1'b1;
    @(negedge clk); a.start = 1'b0;
  endtask

  task automatic wait_valid_a(output int cnt);
    cnt = 0;
    while (!a.code_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic handshake_a();
    @(negedge clk); a.code_ready = 1'b1;
    @(negedge clk); a.code_ready = 1'b0;
    check("valid_clear_after_handshake", a.code_valid, 0);
  endtask

  int lat;
  int waited;
  logic [7:0] held_code;

  initial begin
    n_tests = 0; n_fail = 0;
    a.start = 0; a.code_ready = 0; b.start = 0; b.code_ready = 0;
    model_a = 8'h39; model_b = 8'h39; toggle_a = 0; cyc_a = 0;

    vecs[0] = '{8'h39, 1'b0, 8'h39, 1'b0};
    vecs[1] = '{8'h69, 1'b0, 8'h69, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h39, 1'b1, 8'h19, 1'b1};

    rst_n = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", a.busy, 0);
    check("reset_dut_in", a.dut_in, 0);
    check("reset_code", a.code, 0);
    check("reset_valid", a.code_valid, 0);
    check("reset_unstable", a.unstable, 0);
    rst_n = 1;

    for (int i = 0; i < 5; i++) begin
      model_a = vecs[i].model;
      toggle_a = vecs[i].toggle;
      start_a();
      check("busy_after_start", a.busy, 1);
      wait_valid_a(lat);
      check("latency", lat, 49);
      check("code", a.code, vecs[i].exp_code);
      check("unstable", a.unstable, vecs[i].exp_unstable);
      check("busy_at_valid", a.busy, 0);
      check("dut_in_done", a.dut_in, 0);
      handshake_a();
    end

    // Backpressure with start pulses while code_valid is held.
    model_a = 8'h69; toggle_a = 0;
    start_a();
    wait_valid_a(lat);
    held_code = a.code;
    check("bp_code", held_code, 8'h69);
    for (int i = 0; i < 10; i++) begin
      a.start = (i == 3);
      @(negedge clk);
      check("bp_code_held", a.code, 8'h69);
      check("bp_valid_held", a.code_valid, 1);
      check("bp_unstable_held", a.unstable, 0);
      check("bp_busy_low", a.busy, 0);
      check("bp_dut_in_idle", a.dut_in, 0);
    end
    // Start coincident with the handshake must be ignored.
    a.start = 1; a.code_ready = 1;
    @(negedge clk);
    a.start = 0; a.code_ready = 0;
    check("hs_valid_clear", a.code_valid, 0);
    repeat (3) @(negedge clk);
    check("hs_no_new_sweep", a.busy, 0);
    check("hs_code_retained", a.code, 8'h69);

    // Async reset mid-sweep after unstable has already been set on row 010.
    model_a = 8'h39; toggle_a = 1;
    start_a();
    waited = 0;
    while (a.dut_in != 3'b100 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("reached_row4", a.dut_in, 3'b100);
    check("unstable_before_reset", a.unstable, 1);
    #2 rst_n = 0;
    #1;
    check("async_busy", a.busy, 0);
    check("async_dut_in", a.dut_in, 0);
    check("async_code", a.code, 0);
    check("async_valid", a.code_valid, 0);
    check("async_unstable", a.unstable, 0);
    @(negedge clk); rst_n = 1;
    toggle_a = 0; model_a = 8'h39;
    start_a();
    wait_valid_a(lat);
    check("post_reset_latency", lat, 49);
    check("post_reset_code", a.code, 8'h39);
    check("post_reset_unstable", a.unstable, 0);
    handshake_a();

    // Minimum timing instance: each row held exactly two cycles.
    model_b = 8'h39;
    @(negedge clk); b.start = 1;
    @(negedge clk); b.start = 0;
    for (int j = 0; j < 16; j++) begin
      check("min_dut_in_step", b.dut_in, j / 2);
      @(negedge clk);
    end
    lat = 16;
    while (!b.code_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("min_latency", lat, 17);
    check("min_code", b.code, 8'h39);
    check("min_unstable", b.unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Characterisation block for 3-input logic gates: drives all eight input combinations into a gate under test, samples its output and assembles the 8-bit truth-table code in the same hex convention used to name the gates (for example 0x39).
- Sits between a bench or top-level controller and any 3-input gate instance.
- Turns a function back into its code, the inverse of the gate modules, which turn a code into a function.

Parameters:
- SETTLE_CYCLES, 4: cycles each input row is held before sampling begins; legal range >= 1.
- STABLE_SAMPLES, 2: consecutive cycles dut_out is sampled per row; legal range >= 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; accepted only in IDLE.
- busy  output  1  high from the cycle after start is accepted until code_valid rises.
- dut_in  output  3  registered drive to the gate: dut_in[2]=in1, dut_in[1]=in2, dut_in[0]=in3.
- dut_out  input  1  gate output; treated as synchronous to clk, no synchroniser.
- code  output  8  extracted truth-table code.
- code_valid  output  1  code and unstable are valid; held until accepted.
- code_ready  input  1  consumer accepts the result when code_valid && code_ready.
- unstable  output  1  sticky per sweep: some row saw disagreeing samples.

Behaviour:
- Reset values: busy=0, dut_in=3'b000, code=8'h00, code_valid=0, unstable=0, state=IDLE, all counters 0.
- Reset is asynchronous and may assert mid-sweep. The sweep is discarded and no partial code is ever presented.
- States: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: start=1 moves to SETTLE with row=0, code and unstable cleared, busy=1.
  - SETTLE: dut_in=row. Stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: register dut_out on each of STABLE_SAMPLES consecutive cycles.
    - If any sample differs from the first, set unstable (sticky).
    - The last sample is the recorded value.
    - Write it to code[7-row]: row 3'b000 goes to bit 7, row 3'b111 goes to bit 0.
    - If row<7: row+1, back to SETTLE.
    - If row==7: go to DONE.
  - DONE: code_valid=1, busy=0, dut_in returns to 3'b000.
    - code and unstable are held stable while code_valid=1 && code_ready=0.
    - The handshake moves to IDLE and clears code_valid next cycle. code is retained until the next start.
- Latency: with start sampled high at edge k, code_valid is first high after edge k + 8*(SETTLE_CYCLES+STABLE_SAMPLES) + 1. With defaults that is 49 cycles.
- Boundary rules:
  - start is ignored in every state except IDLE, including while code_valid=1.
  - start and a handshake in the same cycle: the handshake takes effect, start is ignored, and a new start is needed in IDLE.
  - Row counter is 3 bits; its wrap after row 7 is never used because DONE is entered instead.
  - Settle counter width is clog2(SETTLE_CYCLES+1); sample counter width is clog2(STABLE_SAMPLES+1).
  - dut_in changes only on SETTLE entry and on DONE entry, so it never glitches within a row.

Decomposition:
- Shared package tt_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - TT_ROWS=8
  - TT_CODE_W=8
  - the row-to-bit mapping function (bit = 7-row), shared with bench models.
- One natural sub-module, tt_row_sampler: owns the settle and sample counters and the stability compare, and returns sample_done, sample_bit and mismatch to the top FSM.

Test Plan:
- Gate model implementing code 0x39 (rows 000..111 give 0,0,1,1,1,0,0,1), defaults, one start -> code=8'h39, unstable=0, code_valid first high exactly 49 cycles after start.
- XOR3 model -> code=8'h69. Constant-0 model -> 8'h00. Constant-1 model -> 8'hFF. All with unstable=0.
- 0x39 model that toggles dut_out during the SAMPLE window of row 3'b010 -> unstable=1; code bit 5 equals the last sample taken.
- Backpressure:
  - code_ready held low 10 cycles after code_valid, with start pulsed during that time -> code and unstable stay constant, no new sweep starts, busy stays 0.
  - Handshake then returns to IDLE.
- rst_n asserted while dut_in=3'b100 -> all outputs at reset values immediately, asynchronously.
  - After release, a fresh start -> correct code with no carry-over of bits or of unstable.
- SETTLE_CYCLES=1, STABLE_SAMPLES=1 -> code_valid high 17 cycles after start; dut_in steps through 000..111, each row held exactly 2 cycles.
